// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the multi-cycle CPU and RAM/7-seg/LED/switches.
// One access in flight; RAM accesses wait RAM_LAT cycles, all others respond next cycle.
module mio_bus_ctrl #(
    parameter int RAM_LAT = 2,
    parameter int RAM_AW  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [31:0]       seg_data,
    output logic [15:0]       led_out,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        T_RAM,
        T_SEG,
        T_LED,
        T_ERR
    } tgt_t;

    localparam logic [3:0] CNT_INIT = 4'(RAM_LAT - 1);

    state_t            state;
    state_t            state_nx;
    tgt_t              tgt;
    logic [3:0]        cnt;
    logic [RAM_AW-1:0] addr_q;
    logic              we_q;
    logic              accept;
    logic              ram_hit;
    logic              seg_hit;
    logic              led_hit;
    logic [RAM_AW-1:0] cpu_idx;

    assign accept  = (state == IDLE) && cpu_req;
    assign cpu_idx = cpu_addr[RAM_AW+1:2];

    assign ram_hit = (cpu_addr[1:0] == 2'b00)
                  && (cpu_addr[31:28] == 4'h0)
                  && ((cpu_addr[27:0] >> (RAM_AW + 2)) == 28'd0);
    assign seg_hit = (cpu_addr == 32'hD000_0000);
    assign led_hit = (cpu_addr == 32'hE000_0000);

    always_comb begin
        tgt = T_ERR;
        unique case (1'b1)
            ram_hit: tgt = T_RAM;
            seg_hit: tgt = T_SEG;
            led_hit: tgt = T_LED;
            default: tgt = T_ERR;
        endcase
    end

    // The synchronous RAM sees the request address at acceptance, so its
    // registered output is already valid when RAM_LAT is 1.
    assign ram_addr  = (accept && reset) ? cpu_idx : addr_q;
    assign cpu_ready = (state == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nx = (tgt == T_RAM) ? RAM_WAIT : RESP;
                end
            end
            RAM_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= 32'd0;
            cpu_rdata <= 32'd0;
            seg_data  <= 32'd0;
            led_out   <= 16'd0;
            bus_err   <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (accept) begin
                addr_q    <= cpu_idx;
                we_q      <= cpu_we;
                ram_wdata <= cpu_wdata;
                cnt       <= CNT_INIT;
                unique case (tgt)
                    T_RAM: ram_we <= cpu_we;
                    T_SEG: begin
                        if (cpu_we) seg_data <= cpu_wdata;
                        else        cpu_rdata <= seg_data;
                    end
                    T_LED: begin
                        if (cpu_we) led_out <= cpu_wdata[15:0];
                        else        cpu_rdata <= {sw_in, led_out};
                    end
                    T_ERR: begin
                        bus_err   <= 1'b1;
                        cpu_rdata <= 32'hDEAD_BEEF;
                    end
                endcase
            end else if (state == RAM_WAIT) begin
                if (cnt == 4'd0) begin
                    if (!we_q) cpu_rdata <= ram_rdata;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: three instances with RAM_LAT 2, 1 and 4,
// each attached to its own synchronous RAM model.
module tb_mio_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req [3];
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [15:0] sw_in;

    logic [31:0] rdata  [3];
    logic        ready  [3];
    logic [9:0]  raddr  [3];
    logic        rwe    [3];
    logic [31:0] rwdata [3];
    logic [31:0] rrdata [3];
    logic [31:0] seg    [3];
    logic [15:0] led    [3];
    logic        berr   [3];

    logic [31:0] mem [3][1024];

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    logic [9:0]  we_addr = '0;
    logic [31:0] we_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rwe[i]) mem[i][raddr[i]] <= rwdata[i];
            rrdata[i] <= mem[i][raddr[i]];
        end
    end

    always @(posedge clk) begin
        if (rwe[0]) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= raddr[0];
            we_data <= rwdata[0];
        end
    end

    mio_bus_ctrl #(.RAM_LAT(2), .RAM_AW(10)) u0 (
        .clk(clk), .reset(reset), .cpu_req(req[0]), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata[0]),
        .cpu_ready(ready[0]), .ram_addr(raddr[0]), .ram_we(rwe[0]),
        .ram_wdata(rwdata[0]), .ram_rdata(rrdata[0]), .sw_in(sw_in),
        .seg_data(seg[0]), .led_out(led[0]), .bus_err(berr[0])
    );

    mio_bus_ctrl #(.RAM_LAT(1), .RAM_AW(10)) u1 (
        .clk(clk), .reset(reset), .cpu_req(req[1]), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata[1]),
        .cpu_ready(ready[1]), .ram_addr(raddr[1]), .ram_we(rwe[1]),
        .ram_wdata(rwdata[1]), .ram_rdata(rrdata[1]), .sw_in(sw_in),
        .seg_data(seg[1]), .led_out(led[1]), .bus_err(berr[1])
    );

    mio_bus_ctrl #(.RAM_LAT(4), .RAM_AW(10)) u2 (
        .clk(clk), .reset(reset), .cpu_req(req[2]), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata[2]),
        .cpu_ready(ready[2]), .ram_addr(raddr[2]), .ram_we(rwe[2]),
        .ram_wdata(rwdata[2]), .ram_rdata(rrdata[2]), .sw_in(sw_in),
        .seg_data(seg[2]), .led_out(led[2]), .bus_err(berr[2])
    );

    function automatic logic [127:0] outs(input int u);
        return {3'b000, rdata[u], ready[u], raddr[u], rwe[u],
                rwdata[u], seg[u], led[u], berr[u]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access on instance u, scramble the CPU inputs after acceptance,
    // then measure the number of edges after E until RESP and the pulse width.
    task automatic acc(input int u, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input int rel,
                       input logic chk_rd, input logic [31:0] exp_rd,
                       input string tag);
        int k;
        logic [31:0] got;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        req[u]    = 1'b1;
        tick();
        req[u]    = 1'b0;
        cpu_addr  = ~a;
        cpu_wdata = ~d;
        cpu_we    = ~we;
        sw_in     = ~sw_in;
        k = 0;
        while (!ready[u] && k < 20) begin
            tick();
            k++;
        end
        got = rdata[u];
        chk({tag, "_lat"}, 128'(k), 128'(rel));
        if (chk_rd) chk({tag, "_rd"}, 128'(got), 128'(exp_rd));
        tick();
        chk({tag, "_pulse"}, 128'(ready[u]), 128'd0);
    endtask

    initial begin
        int n;
        int c0;
        reset     = 1'b0;
        req[0]    = 1'b0;
        req[1]    = 1'b0;
        req[2]    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        sw_in     = 16'd0;
        repeat (3) tick();
        chk("por_outs", outs(0), 128'd0);
        reset = 1'b1;
        tick();

        acc(0, 1'b1, 32'h0000_0100, 32'd0, 2, 1'b0, 32'd0, "init_w");

        // Reset in the first RAM_WAIT cycle of a write
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0100;
        cpu_wdata = 32'h0000_AAAA;
        req[0]    = 1'b1;
        tick();
        chk("rst_we_pre", 128'(rwe[0]), 128'd1);
        req[0] = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_outs", outs(0), 128'd0);
        repeat (2) tick();
        chk("rst_hold", outs(0), 128'd0);
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_idle", outs(0), 128'd0);

        // RAM write, RAM_LAT=2
        c0 = we_cnt;
        acc(0, 1'b1, 32'h0000_03E0, 32'h1, 2, 1'b0, 32'd0, "ram_w");
        chk("ram_w_cnt", 128'(we_cnt - c0), 128'd1);
        chk("ram_w_addr", 128'(we_addr), 128'h0F8);
        chk("ram_w_data", 128'(we_data), 128'h1);

        // RAM reads; the aborted write must not have landed
        acc(0, 1'b0, 32'h0000_0100, 32'd0, 2, 1'b1, 32'd0, "ram_r_abort");
        acc(0, 1'b0, 32'h0000_03E0, 32'd0, 2, 1'b1, 32'h1, "ram_r");

        acc(1, 1'b1, 32'h0000_03E0, 32'h1, 1, 1'b0, 32'd0, "l1_w");
        acc(1, 1'b0, 32'h0000_03E0, 32'd0, 1, 1'b1, 32'h1, "l1_r");
        acc(2, 1'b1, 32'h0000_03E0, 32'h1, 4, 1'b0, 32'd0, "l4_w");
        acc(2, 1'b0, 32'h0000_03E0, 32'd0, 4, 1'b1, 32'h1, "l4_r");

        // 7-seg: a write leaves cpu_rdata at the previous read value
        acc(0, 1'b1, 32'hD000_0000, 32'h1234_5678, 0, 1'b1, 32'h1, "seg_w");
        chk("seg_val", 128'(seg[0]), 128'h1234_5678);
        acc(0, 1'b0, 32'hD000_0000, 32'd0, 0, 1'b1, 32'h1234_5678, "seg_r");

        // LED / switches
        sw_in = 16'h1234;
        acc(0, 1'b1, 32'hE000_0000, 32'hFFFF_00A5, 0, 1'b0, 32'd0, "led_w");
        chk("led_val", 128'(led[0]), 128'h00A5);
        sw_in = 16'h1234;
        acc(0, 1'b0, 32'hE000_0000, 32'd0, 0, 1'b1, 32'h1234_00A5, "led_r");

        // Errors
        chk("err_clear", 128'(berr[0]), 128'd0);
        acc(0, 1'b0, 32'h0000_0002, 32'd0, 0, 1'b1, 32'hDEAD_BEEF, "err_r");
        chk("err_set", 128'(berr[0]), 128'd1);
        c0 = we_cnt;
        acc(0, 1'b1, 32'h8000_0000, 32'hCAFE, 0, 1'b1, 32'hDEAD_BEEF, "err_w");
        chk("err_sticky", 128'(berr[0]), 128'd1);
        chk("err_no_ramwe", 128'(we_cnt - c0), 128'd0);
        chk("err_seg", 128'(seg[0]), 128'h1234_5678);
        chk("err_led", 128'(led[0]), 128'h00A5);
        acc(0, 1'b0, 32'h0000_03E0, 32'd0, 2, 1'b1, 32'h1, "err_ram_r");
        chk("err_sticky2", 128'(berr[0]), 128'd1);

        // Back-to-back with cpu_req held high: SEG every 2 cycles
        cpu_we   = 1'b0;
        cpu_addr = 32'hD000_0000;
        req[0]   = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready[0]) begin
                n++;
                chk("b2b_seg_rd", 128'(rdata[0]), 128'h1234_5678);
            end
        end
        chk("b2b_seg_n", 128'(n), 128'd5);

        // RAM reads every 4 cycles with RAM_LAT=2
        cpu_addr = 32'h0000_03E0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ready[0]) begin
                n++;
                chk("b2b_ram_rd", 128'(rdata[0]), 128'h1);
            end
        end
        chk("b2b_ram_n", 128'(n), 128'd3);
        req[0] = 1'b0;
        repeat (2) tick();
        chk("b2b_done", 128'(ready[0]), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
